// File: rtl/cell_bank_server.sv
// rtl/cell_bank_server.sv - double-buffered cell bank responder for the generation engine
// Optional build macro: POP_COUNT_EN (adds the population output and live-write accumulator)
module cell_bank_server #(
   parameter int P_PARAM_M = 5,
   parameter int P_PARAM_N = 5,
   parameter int WIDTH     = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               evo_start,
   input  logic               evo_done,
   input  logic               rden,
   input  logic [2*WIDTH-1:0] round_read_pos,
   output logic               prev_status,
   input  logic               wden,
   input  logic [2*WIDTH-1:0] round_write_pos,
   input  logic               live,
   input  logic               load_en,
   input  logic [2*WIDTH-1:0] load_pos,
   input  logic               load_data,
   input  logic               clear_req,
   input  logic [2*WIDTH-1:0] disp_pos,
   output logic               disp_status,
   output logic               busy,
   output logic               bank_sel,
`ifdef POP_COUNT_EN
   output logic [2*WIDTH-1:0] population,
`endif
   output logic [15:0]        gen_count
);

   localparam int N_CELLS = P_PARAM_M * P_PARAM_N;
   localparam int AW      = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
   localparam logic [2*WIDTH-1:0] N_CELLS_P = (2*WIDTH)'(N_CELLS);
   localparam logic [AW-1:0]      LAST_CELL = AW'(N_CELLS - 1);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EVOLVING, S_SWAP} state_t;

   state_t             state_q;
   logic [AW-1:0]      clr_cnt_q;
   logic               bank_sel_q;
   logic [15:0]        gen_count_q;
   logic               busy_q;
   logic               prev_status_q;
   logic               disp_status_q;
   logic [N_CELLS-1:0] bank0_q;
   logic [N_CELLS-1:0] bank1_q;

   logic [N_CELLS-1:0] front_d;
   logic               serving_d;
   logic               rd_ok_d;
   logic               disp_ok_d;
   logic               eng_wr_d;
   logic               ld_wr_d;

   // Front bank selection and access qualification; positions past the grid are never served or written
   assign front_d   = bank_sel_q ? bank1_q : bank0_q;
   assign serving_d = (state_q == S_IDLE) || (state_q == S_EVOLVING);
   assign rd_ok_d   = rden && serving_d && (round_read_pos < N_CELLS_P);
   assign disp_ok_d = (state_q != S_CLEAR) && (disp_pos < N_CELLS_P);
   assign eng_wr_d  = wden && (state_q == S_EVOLVING) && (round_write_pos < N_CELLS_P);
   assign ld_wr_d   = load_en && (state_q == S_IDLE) && (load_pos < N_CELLS_P);

   // Cell storage: sweep-clear both banks in CLEAR, engine writes the back bank, loads write the front bank
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         bank0_q[clr_cnt_q] <= 1'b0;
         bank1_q[clr_cnt_q] <= 1'b0;
      end
      if (eng_wr_d) begin
         if (bank_sel_q) bank0_q[round_write_pos[AW-1:0]] <= live;
         else            bank1_q[round_write_pos[AW-1:0]] <= live;
      end
      if (ld_wr_d) begin
         if (bank_sel_q) bank1_q[load_pos[AW-1:0]] <= load_data;
         else            bank0_q[load_pos[AW-1:0]] <= load_data;
      end
   end

   // Registered read ports; sampling before the bank update gives read-before-write semantics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_status_q <= 1'b0;
         disp_status_q <= 1'b0;
      end else begin
         prev_status_q <= rd_ok_d   ? front_d[round_read_pos[AW-1:0]] : 1'b0;
         disp_status_q <= disp_ok_d ? front_d[disp_pos[AW-1:0]]       : 1'b0;
      end
   end

   // Control FSM: clear sweep, idle, evolving, one-cycle bank swap; busy is registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         clr_cnt_q   <= '0;
         bank_sel_q  <= 1'b0;
         gen_count_q <= 16'd0;
         busy_q      <= 1'b1;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_cnt_q == LAST_CELL) begin
                  clr_cnt_q <= '0;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (clear_req) begin
                  clr_cnt_q <= '0;
                  state_q   <= S_CLEAR;
                  busy_q    <= 1'b1;
               end else if (evo_start) begin
                  state_q <= S_EVOLVING;
               end
            end
            S_EVOLVING: begin
               if (clear_req) begin
                  clr_cnt_q <= '0;
                  state_q   <= S_CLEAR;
                  busy_q    <= 1'b1;
               end else if (evo_done) begin
                  state_q <= S_SWAP;
                  busy_q  <= 1'b1;
               end
            end
            S_SWAP: begin
               bank_sel_q  <= ~bank_sel_q;
               gen_count_q <= gen_count_q + 16'd1;
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
            end
            default: begin
               clr_cnt_q <= '0;
               state_q   <= S_CLEAR;
               busy_q    <= 1'b1;
            end
         endcase
      end
   end

`ifdef POP_COUNT_EN
   logic [2*WIDTH-1:0] pop_acc_q;
   logic [2*WIDTH-1:0] population_q;

   // Live-cell accumulator for the generation in flight, published at the swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_acc_q    <= '0;
         population_q <= '0;
      end else begin
         case (state_q)
            S_CLEAR:    population_q <= '0;
            S_IDLE:     if (!clear_req && evo_start) pop_acc_q <= '0;
            S_EVOLVING: if (eng_wr_d && live) pop_acc_q <= pop_acc_q + 1'b1;
            S_SWAP:     population_q <= pop_acc_q;
            default:    population_q <= '0;
         endcase
      end
   end

   assign population = population_q;
`endif

   assign prev_status = prev_status_q;
   assign disp_status = disp_status_q;
   assign busy        = busy_q;
   assign bank_sel    = bank_sel_q;
   assign gen_count   = gen_count_q;

endmodule

// File: tb/tb_cell_bank_server.sv
// tb/tb_cell_bank_server.sv - scoreboard bench for cell_bank_server (5x5 grid)
module tb_cell_bank_server;

   localparam int M  = 5;
   localparam int N  = 5;
   localparam int W  = 12;
   localparam int NC = M * N;

   typedef struct {
      int   pos;
      logic v;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          evo_start, evo_done, rden, wden, live, load_en, load_data, clear_req;
   logic [2*W-1:0] round_read_pos, round_write_pos, load_pos, disp_pos;
   logic          prev_status, disp_status, busy, bank_sel;
   logic [15:0]   gen_count;
`ifdef POP_COUNT_EN
   logic [2*W-1:0] population;
`endif

   int   vec  = 0;
   int   miss = 0;
   exp_t sb_q[$];
   exp_t e;

   always #5 clk = ~clk;

   cell_bank_server #(.P_PARAM_M(M), .P_PARAM_N(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .evo_start(evo_start), .evo_done(evo_done),
      .rden(rden), .round_read_pos(round_read_pos), .prev_status(prev_status),
      .wden(wden), .round_write_pos(round_write_pos), .live(live),
      .load_en(load_en), .load_pos(load_pos), .load_data(load_data),
      .clear_req(clear_req), .disp_pos(disp_pos), .disp_status(disp_status),
      .busy(busy), .bank_sel(bank_sel),
`ifdef POP_COUNT_EN
      .population(population),
`endif
      .gen_count(gen_count)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_read(input int pos, input logic v);
      exp_t x;
      rden           = 1'b1;
      round_read_pos = pos[2*W-1:0];
      x.pos = pos;
      x.v   = v;
      sb_q.push_back(x);
   endtask

   task automatic test_reset();
      int cnt;
      rst_n = 1'b0;
      {evo_start, evo_done, rden, wden, live, load_en, load_data, clear_req} = '0;
      round_read_pos = '0; round_write_pos = '0; load_pos = '0; disp_pos = '0;
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if ({busy, bank_sel, gen_count, prev_status, disp_status} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
         miss++;
         $display("FAIL reset_state busy=%b sel=%b gen=%0d prev=%b disp=%b, required 1 0 0 0 0",
                  busy, bank_sel, gen_count, prev_status, disp_status);
      end
      rst_n = 1'b1;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      vec++;
      if (cnt != NC) begin
         miss++;
         $display("FAIL reset_clear_len busy cycles=%0d, required %0d", cnt, NC);
      end
      for (int p = 0; p <= NC; p++) begin
         disp_pos = p[2*W-1:0];
         sb_q.push_back('{pos: p, v: 1'b0});
         tick();
         e = sb_q.pop_front();
         vec++;
         if (disp_status !== e.v) begin
            miss++;
            $display("FAIL reset_disp pos=%0d got %b, required %b", e.pos, disp_status, e.v);
         end
      end
   endtask

   task automatic test_load_read();
      int   pos_t[6] = '{7, 8, 25, 9, 6, 16777215};
      logic exp_t_v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      load_en = 1'b1; load_pos = 7; load_data = 1'b1;
      tick();
      load_pos = 9;
      push_read(9, 1'b0);
      tick();
      load_en = 1'b0; rden = 1'b0;
      e = sb_q.pop_front();
      vec++;
      if (prev_status !== e.v) begin
         miss++;
         $display("FAIL load_rbw pos=%0d got %b, required %b", e.pos, prev_status, e.v);
      end
      for (int i = 0; i < 6; i++) begin
         push_read(pos_t[i], exp_t_v[i]);
         tick();
         e = sb_q.pop_front();
         vec++;
         if (prev_status !== e.v) begin
            miss++;
            $display("FAIL load_read pos=%0d got %b, required %b", e.pos, prev_status, e.v);
         end
      end
      rden = 1'b0;
      tick();
      vec++;
      if (prev_status !== 1'b0) begin
         miss++;
         $display("FAIL read_no_enable got %b, required 0", prev_status);
      end
      disp_pos = 7;
      tick();
      vec++;
      if (disp_status !== 1'b1) begin
         miss++;
         $display("FAIL load_disp pos=7 got %b, required 1", disp_status);
      end
   endtask

   task automatic test_evolve();
      int   pos_t[3] = '{3, 7, 9};
      logic exp_t_v[3] = '{1'b1, 1'b0, 1'b0};
      evo_start = 1'b1;
      tick();
      evo_start = 1'b0;
      wden = 1'b1; round_write_pos = 3; live = 1'b1;
      tick();
      wden = 1'b0;
      push_read(3, 1'b0);
      tick();
      rden = 1'b0;
      e = sb_q.pop_front();
      vec++;
      if (prev_status !== e.v) begin
         miss++;
         $display("FAIL evolve_front_kept pos=%0d got %b, required %b", e.pos, prev_status, e.v);
      end
      evo_done = 1'b1;
      tick();
      evo_done = 1'b0;
      vec++;
      if ({busy, bank_sel, gen_count} !== {1'b1, 1'b0, 16'd0}) begin
         miss++;
         $display("FAIL swap_state busy=%b sel=%b gen=%0d, required 1 0 0", busy, bank_sel, gen_count);
      end
      push_read(7, 1'b0);
      tick();
      rden = 1'b0;
      e = sb_q.pop_front();
      vec++;
      if (prev_status !== e.v) begin
         miss++;
         $display("FAIL swap_read pos=%0d got %b, required %b", e.pos, prev_status, e.v);
      end
      vec++;
      if ({busy, bank_sel, gen_count} !== {1'b0, 1'b1, 16'd1}) begin
         miss++;
         $display("FAIL after_swap busy=%b sel=%b gen=%0d, required 0 1 1", busy, bank_sel, gen_count);
      end
      for (int i = 0; i < 3; i++) begin
         push_read(pos_t[i], exp_t_v[i]);
         tick();
         e = sb_q.pop_front();
         vec++;
         if (prev_status !== e.v) begin
            miss++;
            $display("FAIL new_front pos=%0d got %b, required %b", e.pos, prev_status, e.v);
         end
      end
      rden = 1'b0;
   endtask

   task automatic test_ignored_writes();
      int   pos_t[4] = '{4, 5, 7, 3};
      logic exp_t_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      wden = 1'b1; round_write_pos = 5; live = 1'b1;
      tick();
      wden = 1'b0;
      evo_start = 1'b1;
      tick();
      load_en = 1'b1; load_pos = 4; load_data = 1'b1;
      tick();
      load_en = 1'b0;
      wden = 1'b1; round_write_pos = 25; live = 1'b1;
      push_read(4, 1'b0);
      tick();
      wden = 1'b0;
      e = sb_q.pop_front();
      vec++;
      if (prev_status !== e.v) begin
         miss++;
         $display("FAIL evolving_load_ignored pos=%0d got %b, required %b", e.pos, prev_status, e.v);
      end
      push_read(3, 1'b1);
      tick();
      rden = 1'b0; evo_start = 1'b0;
      e = sb_q.pop_front();
      vec++;
      if (prev_status !== e.v) begin
         miss++;
         $display("FAIL evolving_read pos=%0d got %b, required %b", e.pos, prev_status, e.v);
      end
      evo_done = 1'b1;
      tick();
      evo_done = 1'b0;
      tick();
      vec++;
      if ({busy, bank_sel, gen_count} !== {1'b0, 1'b0, 16'd2}) begin
         miss++;
         $display("FAIL second_swap busy=%b sel=%b gen=%0d, required 0 0 2", busy, bank_sel, gen_count);
      end
      for (int i = 0; i < 4; i++) begin
         push_read(pos_t[i], exp_t_v[i]);
         tick();
         e = sb_q.pop_front();
         vec++;
         if (prev_status !== e.v) begin
            miss++;
            $display("FAIL ignored_writes pos=%0d got %b, required %b", e.pos, prev_status, e.v);
         end
      end
      rden = 1'b0;
   endtask

   task automatic test_clear_abort();
      int cnt;
      evo_start = 1'b1;
      tick();
      evo_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wden = 1'b1; round_write_pos = i[2*W-1:0]; live = 1'b1;
         tick();
      end
      wden = 1'b0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      vec++;
      if (cnt != NC || bank_sel !== 1'b0 || gen_count !== 16'd2) begin
         miss++;
         $display("FAIL abort_clear cycles=%0d sel=%b gen=%0d, required %0d 0 2", cnt, bank_sel, gen_count, NC);
      end
      evo_start = 1'b1;
      tick();
      evo_start = 1'b0;
      evo_done = 1'b1;
      tick();
      evo_done = 1'b0;
      tick();
      vec++;
      if ({bank_sel, gen_count} !== {1'b1, 16'd3}) begin
         miss++;
         $display("FAIL empty_swap sel=%b gen=%0d, required 1 3", bank_sel, gen_count);
      end
      for (int p = 0; p < NC; p++) begin
         push_read(p, 1'b0);
         tick();
         e = sb_q.pop_front();
         vec++;
         if (prev_status !== e.v) begin
            miss++;
            $display("FAIL cleared_cell pos=%0d got %b, required %b", e.pos, prev_status, e.v);
         end
      end
      rden = 1'b0;
   endtask

   task automatic test_clear_priority();
      int cnt;
      clear_req = 1'b1; evo_start = 1'b1;
      tick();
      clear_req = 1'b0; evo_start = 1'b0;
      vec++;
      if (busy !== 1'b1) begin
         miss++;
         $display("FAIL clear_priority busy=%b, required 1", busy);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      vec++;
      if (cnt != NC || gen_count !== 16'd3) begin
         miss++;
         $display("FAIL idle_clear cycles=%0d gen=%0d, required %0d 3", cnt, gen_count, NC);
      end
   endtask

`ifdef POP_COUNT_EN
   task automatic test_popcount();
      int cnt;
      evo_start = 1'b1;
      tick();
      evo_start = 1'b0;
      for (int i = 0; i < NC; i++) begin
         wden = 1'b1; round_write_pos = i[2*W-1:0]; live = (i < 6);
         tick();
      end
      wden = 1'b0;
      evo_done = 1'b1;
      tick();
      evo_done = 1'b0;
      tick();
      vec++;
      if (population !== 24'd6) begin
         miss++;
         $display("FAIL popcount got %0d, required 6", population);
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      vec++;
      if (population !== 24'd0) begin
         miss++;
         $display("FAIL popcount_clear got %0d, required 0", population);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      vec++;
      if (cnt != NC - 1) begin
         miss++;
         $display("FAIL popcount_clear_len cycles=%0d, required %0d", cnt, NC - 1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_read();
      test_evolve();
      test_ignored_writes();
      test_clear_abort();
      test_clear_priority();
`ifdef POP_COUNT_EN
      test_popcount();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
